// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one 32-bit slave port, the bus is
// held for the owner's whole cycle, and a watchdog errors strobes that stall too long.
`timescale 1ns/1ps

module wb_rr_arbiter_lane (
   input  logic own,
   input  logic cyc,
   input  logic stb,
   input  logic rst,
   input  logic s_ack,
   input  logic s_err,
   input  logic to_fire,
   output logic req,
   output logic ack,
   output logic err
);
   assign req = cyc & stb;
   assign ack = own & s_ack & ~rst;
   assign err = own & (s_err | to_fire) & ~rst;
endmodule

module wb_rr_arbiter #(
   parameter int C_NUM_MASTERS  = 2,
   parameter int C_TIMEOUT      = 1024,
   parameter int C_TO_CNT_WIDTH = 16
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,
   input  logic [C_NUM_MASTERS-1:0]      m_cyc_i,
   input  logic [C_NUM_MASTERS-1:0]      m_stb_i,
   input  logic [C_NUM_MASTERS-1:0]      m_we_i,
   input  logic [4*C_NUM_MASTERS-1:0]    m_sel_i,
   input  logic [32*C_NUM_MASTERS-1:0]   m_adr_i,
   input  logic [32*C_NUM_MASTERS-1:0]   m_dat_i,
   output logic [31:0]                   m_dat_o,
   output logic [C_NUM_MASTERS-1:0]      m_ack_o,
   output logic [C_NUM_MASTERS-1:0]      m_err_o,
   output logic                          s_cyc_o,
   output logic                          s_stb_o,
   output logic                          s_we_o,
   output logic [3:0]                    s_sel_o,
   output logic [31:0]                   s_adr_o,
   output logic [31:0]                   s_dat_o,
   input  logic [31:0]                   s_dat_i,
   input  logic                          s_ack_i,
   input  logic                          s_err_i,
   output logic [C_NUM_MASTERS-1:0]      grant_o,
   output logic [C_TO_CNT_WIDTH-1:0]     to_count_o
);
   localparam int OW = (C_NUM_MASTERS > 1) ? $clog2(C_NUM_MASTERS) : 1;
   localparam int TW = $clog2(C_TIMEOUT);
   localparam logic [C_NUM_MASTERS-1:0] ONE = C_NUM_MASTERS'(1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                     state;
   logic [OW-1:0]              owner, last_owner, nxt_owner;
   logic [TW-1:0]              timer;
   logic [C_TO_CNT_WIDTH-1:0]  to_count;
   logic [C_NUM_MASTERS-1:0]   req, own_vec;
   logic                       any_req, own_valid, own_cyc, own_stb, own_we;
   logic [3:0]                 own_sel;
   logic [31:0]                own_adr, own_dat;
   logic                       busy, to_cycle, to_fire, stb_gated;

   // Owner mux; an out-of-range owner leaves own_valid low and is bounced to IDLE.
   always_comb begin
      own_vec   = '0;
      own_valid = 1'b0;
      own_cyc   = 1'b0;
      own_stb   = 1'b0;
      own_we    = 1'b0;
      own_sel   = '0;
      own_adr   = '0;
      own_dat   = '0;
      for (int k = 0; k < C_NUM_MASTERS; k++) begin
         if (owner == OW'(k)) begin
            own_vec[k] = (state == BUSY);
            own_valid  = 1'b1;
            own_cyc    = m_cyc_i[k];
            own_stb    = m_stb_i[k];
            own_we     = m_we_i[k];
            own_sel    = m_sel_i[4*k +: 4];
            own_adr    = m_adr_i[32*k +: 32];
            own_dat    = m_dat_i[32*k +: 32];
         end
      end
   end

   // Lowest offset from last_owner wins, so walk the offsets from far to near.
   always_comb begin
      any_req   = 1'b0;
      nxt_owner = last_owner;
      for (int i = C_NUM_MASTERS; i >= 1; i--) begin
         if (req[OW'((int'(last_owner) + i) % C_NUM_MASTERS)]) begin
            any_req   = 1'b1;
            nxt_owner = OW'((int'(last_owner) + i) % C_NUM_MASTERS);
         end
      end
   end

   assign busy      = (state == BUSY) && own_valid;
   assign to_cycle  = busy && own_stb && (timer == TW'(C_TIMEOUT - 1));
   // A slave response in the watchdog cycle takes precedence over the timeout error.
   assign to_fire   = to_cycle && !s_ack_i && !s_err_i;
   assign stb_gated = busy && own_stb && !to_cycle;

   assign s_cyc_o    = busy && own_cyc && !wb_rst_i;
   assign s_stb_o    = stb_gated && !wb_rst_i;
   assign s_we_o     = own_we;
   assign s_sel_o    = own_sel;
   assign s_adr_o    = own_adr;
   assign s_dat_o    = own_dat;
   assign m_dat_o    = s_dat_i;
   assign to_count_o = to_count;

   for (genvar k = 0; k < C_NUM_MASTERS; k++) begin : g_lane
      wb_rr_arbiter_lane u_lane (
         .own     (own_vec[k]),
         .cyc     (m_cyc_i[k]),
         .stb     (m_stb_i[k]),
         .rst     (wb_rst_i),
         .s_ack   (s_ack_i),
         .s_err   (s_err_i),
         .to_fire (to_fire),
         .req     (req[k]),
         .ack     (m_ack_o[k]),
         .err     (m_err_o[k])
      );
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= OW'(C_NUM_MASTERS - 1);
         grant_o    <= '0;
         timer      <= '0;
         to_count   <= '0;
      end else begin
         if (to_fire && (to_count != '1))
            to_count <= to_count + C_TO_CNT_WIDTH'(1);
         case (state)
            IDLE: begin
               timer <= '0;
               if (any_req) begin
                  owner   <= nxt_owner;
                  grant_o <= ONE << nxt_owner;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (!own_valid) begin
                  state   <= IDLE;
                  grant_o <= '0;
                  timer   <= '0;
               end else if (!own_cyc) begin
                  last_owner <= owner;
                  state      <= IDLE;
                  grant_o    <= '0;
                  timer      <= '0;
               end else if (to_cycle || !stb_gated || s_ack_i || s_err_i) begin
                  timer <= '0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               grant_o <= '0;
               timer   <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: 3 masters, 8-cycle watchdog, 2-bit timeout counter,
// behavioural register slave and a round-robin/memory reference model.
`timescale 1ns/1ps

module tb_wb_rr_arbiter;
   localparam int N  = 3;
   localparam int TO = 8;
   localparam int CW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      m_cyc, m_stb, m_we;
   logic [4*N-1:0]    m_sel;
   logic [32*N-1:0]   m_adr, m_dat;
   logic [31:0]       m_dat_o;
   logic [N-1:0]      m_ack, m_err, grant;
   logic              s_cyc, s_stb, s_we;
   logic [3:0]        s_sel;
   logic [31:0]       s_adr, s_dat;
   logic [CW-1:0]     to_count;

   logic [31:0]       smem [16];
   logic [31:0]       ref_mem [16];
   logic [31:0]       sl_rdat;
   logic              sl_ack, sl_err, ack_force, s_ack;
   int                sl_cnt, sl_wait;
   bit                sl_err_mode;
   int                n_cmp, n_bad;
   int                glob_last;

   assign s_ack = sl_ack | ack_force;

   always #5 clk = ~clk;

   wb_rr_arbiter #(.C_NUM_MASTERS(N), .C_TIMEOUT(TO), .C_TO_CNT_WIDTH(CW)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
      .m_ack_o(m_ack), .m_err_o(m_err),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
      .s_adr_o(s_adr), .s_dat_o(s_dat), .s_dat_i(sl_rdat),
      .s_ack_i(s_ack), .s_err_i(sl_err),
      .grant_o(grant), .to_count_o(to_count)
   );

   // Register slave: answers after sl_wait extra cycles, optionally with err.
   always @(posedge clk) begin
      if (s_cyc && s_stb && !sl_ack && !sl_err) begin
         if (sl_cnt >= sl_wait) begin
            sl_cnt <= 0;
            if (sl_err_mode) sl_err <= 1'b1;
            else begin
               sl_ack <= 1'b1;
               if (s_we) begin
                  for (int b = 0; b < 4; b++)
                     if (s_sel[b]) smem[s_adr[5:2]][8*b +: 8] <= s_dat[8*b +: 8];
               end else sl_rdat <= smem[s_adr[5:2]];
            end
         end else sl_cnt <= sl_cnt + 1;
      end else begin
         sl_ack <= 1'b0;
         sl_err <= 1'b0;
         sl_cnt <= 0;
      end
   end

   function automatic int rr_pick(input int last, input logic [N-1:0] r);
      for (int d = 1; d <= N; d++)
         if (r[(last + d) % N]) return (last + d) % N;
      return -1;
   endfunction

   task automatic set_req(input int k, input logic we, input logic [31:0] adr, dat,
                          input logic [3:0] sel);
      m_cyc[k] = 1'b1; m_stb[k] = 1'b1; m_we[k] = we;
      m_adr[32*k +: 32] = adr; m_dat[32*k +: 32] = dat; m_sel[4*k +: 4] = sel;
   endtask

   task automatic drop(input int k);
      m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Waits for master k's response; returns one tick after the edge that consumes it.
   task automatic run_beat(input int k, output logic [N-1:0] ack_v, err_v,
                           output logic [31:0] rdat, adr_seen, wdat_seen, output bit tmo);
      bit done = 0;
      tmo = 1; ack_v = '0; err_v = '0; rdat = '0; adr_seen = '0; wdat_seen = '0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (m_ack[k] || m_err[k]) begin
            ack_v = m_ack; err_v = m_err; rdat = m_dat_o;
            adr_seen = s_adr; wdat_seen = s_dat; tmo = 0; done = 1;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      logic [N-1:0] av, ev; logic [31:0] rd, as, ws; bit tmo;
      rst = 1'b1;
      set_req(0, 1'b0, 32'h0, 32'h0, 4'hF);
      set_req(1, 1'b0, 32'h4, 32'h0, 4'hF);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (s_cyc !== 1'b0) begin n_bad++; $display("FAIL reset_scyc: got %b want 0", s_cyc); end
         n_cmp++; if (grant !== '0) begin n_bad++; $display("FAIL reset_grant: got %b want 000", grant); end
         n_cmp++; if (to_count !== '0) begin n_bad++; $display("FAIL reset_tocnt: got %0d want 0", to_count); end
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL reset_nocomb_grant: got %b want 000", grant); end
      @(negedge clk);
      n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL reset_first_grant: got %b want 001", grant); end
      n_cmp++; if (s_stb !== 1'b1) begin n_bad++; $display("FAIL reset_first_stb: got %b want 1", s_stb); end
      run_beat(0, av, ev, rd, as, ws, tmo);
      n_cmp++; if (tmo || av !== 3'b001) begin n_bad++; $display("FAIL reset_first_ack: got %b want 001 (tmo=%0d)", av, tmo); end
      drop(0); drop(1);
      settle(2);
      glob_last = 0;
   endtask

   task automatic test_contention;
      logic [N-1:0] av, ev; logic [31:0] rd, as, ws; bit tmo;
      set_req(0, 1'b0, 32'h4, 32'h0, 4'hF);
      set_req(1, 1'b0, 32'h8, 32'h0, 4'hF);
      rst = 1'b1; settle(2); rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL cont_pre: got %b want 000", grant); end
      @(negedge clk);
      n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL cont_first: got %b want 001", grant); end
      run_beat(0, av, ev, rd, as, ws, tmo);
      n_cmp++; if (tmo || av !== 3'b001 || rd !== ref_mem[1]) begin n_bad++; $display("FAIL cont_m0_beat: ack %b data %h want 001/%h", av, rd, ref_mem[1]); end
      drop(0);
      @(negedge clk);
      n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL cont_hold: got %b want 001", grant); end
      @(negedge clk);
      n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL cont_idle_gap: got %b want 000", grant); end
      @(negedge clk);
      n_cmp++; if (grant !== 3'b010) begin n_bad++; $display("FAIL cont_second: got %b want 010", grant); end
      run_beat(1, av, ev, rd, as, ws, tmo);
      n_cmp++; if (tmo || av !== 3'b010 || rd !== ref_mem[2]) begin n_bad++; $display("FAIL cont_m1_beat: ack %b data %h want 010/%h", av, rd, ref_mem[2]); end
      drop(1);
      settle(1);
      set_req(0, 1'b0, 32'h4, 32'h0, 4'hF);
      set_req(1, 1'b0, 32'h8, 32'h0, 4'hF);
      @(negedge clk); @(negedge clk);
      n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL cont_alternate: got %b want 001", grant); end
      run_beat(0, av, ev, rd, as, ws, tmo);
      drop(0); drop(1);
      settle(2);
      glob_last = 0;
   endtask

   task automatic test_single_write;
      logic [N-1:0] av, ev; logic [31:0] rd, as, ws; bit tmo;
      set_req(1, 1'b1, 32'h0, 32'hDEADBEEF, 4'hF);
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (grant !== 3'b010) begin n_bad++; $display("FAIL sw_grant: got %b want 010", grant); end
      n_cmp++; if (s_adr !== 32'h0 || s_dat !== 32'hDEADBEEF || s_we !== 1'b1 || s_sel !== 4'hF)
         begin n_bad++; $display("FAIL sw_bus: adr %h dat %h we %b sel %h want 0/deadbeef/1/f", s_adr, s_dat, s_we, s_sel); end
      n_cmp++; if (s_stb !== 1'b1 || m_ack !== 3'b000) begin n_bad++; $display("FAIL sw_t1: stb %b ack %b want 1/000", s_stb, m_ack); end
      @(negedge clk);
      n_cmp++; if (m_ack !== 3'b010) begin n_bad++; $display("FAIL sw_ack_latency: got %b want 010", m_ack); end
      @(posedge clk); #1;
      ref_mem[0] = 32'hDEADBEEF;
      set_req(1, 1'b0, 32'h0, 32'h0, 4'hF);
      run_beat(1, av, ev, rd, as, ws, tmo);
      n_cmp++; if (tmo || av !== 3'b010 || rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_readback: ack %b data %h want 010/deadbeef", av, rd); end
      drop(1);
      settle(2);
      glob_last = 1;
   endtask

   task automatic test_fairness;
      logic [N-1:0] av, ev; logic [31:0] rd, as, ws; bit tmo;
      int exp; bit got;
      set_req(0, 1'b0, 32'h0, 32'h0, 4'hF);
      set_req(1, 1'b0, 32'h4, 32'h0, 4'hF);
      for (int t = 0; t < 4; t++) begin
         exp = rr_pick(glob_last, 3'b011);
         got = 0;
         for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (grant !== '0) got = 1;
         end
         n_cmp++; if (!got || grant !== (N'(1) << exp)) begin n_bad++; $display("FAIL fair_grant%0d: got %b want master %0d", t, grant, exp); end
         run_beat(exp, av, ev, rd, as, ws, tmo);
         n_cmp++; if (tmo || av !== (N'(1) << exp)) begin n_bad++; $display("FAIL fair_ack%0d: got %b want master %0d", t, av, exp); end
         drop(exp);
         settle(1);
         set_req(exp, 1'b0, 32'h0, 32'h0, 4'hF);
         glob_last = exp;
      end
      drop(0); drop(1);
      settle(3);
   endtask

   task automatic test_timeout;
      bit ack8 [5] = '{0, 0, 1, 0, 0};
      int exp_cnt [5] = '{1, 2, 2, 3, 3};
      for (int r = 0; r < 5; r++) begin
         sl_wait = ack8[r] ? 6 : 1000;
         set_req(0, 1'b0, 32'h10, 32'h0, 4'hF);
         @(posedge clk); #1;
         for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_cmp++; if (s_stb !== (i < 8)) begin n_bad++; $display("FAIL to%0d_stb_c%0d: got %b want %0d", r, i, s_stb, (i < 8)); end
            n_cmp++; if (m_err !== ((i == 8 && !ack8[r]) ? 3'b001 : 3'b000))
               begin n_bad++; $display("FAIL to%0d_err_c%0d: got %b", r, i, m_err); end
            if (i == 8) begin
               n_cmp++; if (m_ack !== (ack8[r] ? 3'b001 : 3'b000)) begin n_bad++; $display("FAIL to%0d_ack8: got %b want %0d", r, m_ack, ack8[r]); end
            end
            @(posedge clk); #1;
         end
         drop(0);
         @(negedge clk);
         n_cmp++; if (m_err !== 3'b000) begin n_bad++; $display("FAIL to%0d_err_after: got %b want 000", r, m_err); end
         n_cmp++; if (to_count !== CW'(exp_cnt[r])) begin n_bad++; $display("FAIL to%0d_count: got %0d want %0d", r, to_count, exp_cnt[r]); end
         settle(2);
      end
      sl_wait = 0;
      glob_last = 0;
   endtask

   task automatic test_slave_err;
      logic [N-1:0] av, ev; logic [31:0] rd, as, ws; bit tmo;
      sl_err_mode = 1;
      set_req(2, 1'b1, 32'h20, 32'h12345678, 4'hF);
      run_beat(2, av, ev, rd, as, ws, tmo);
      n_cmp++; if (tmo || ev !== 3'b100 || av !== 3'b000) begin n_bad++; $display("FAIL serr_route: err %b ack %b want 100/000", ev, av); end
      drop(2);
      sl_err_mode = 0;
      @(negedge clk);
      n_cmp++; if (to_count !== CW'(3)) begin n_bad++; $display("FAIL serr_count: got %0d want 3", to_count); end
      settle(2);
      glob_last = 2;
   endtask

   task automatic test_reset_mid;
      sl_wait = 1000;
      set_req(0, 1'b0, 32'h0, 32'h0, 4'hF);
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (s_stb !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_stb: got %b want 1", s_stb); end
      @(posedge clk); #1;
      rst = 1'b1; ack_force = 1'b1;
      @(negedge clk);
      n_cmp++; if (s_stb !== 1'b0 || s_cyc !== 1'b0) begin n_bad++; $display("FAIL rmid_gate: stb %b cyc %b want 0/0", s_stb, s_cyc); end
      n_cmp++; if (m_ack !== 3'b000 || m_err !== 3'b000) begin n_bad++; $display("FAIL rmid_resp: ack %b err %b want 000/000", m_ack, m_err); end
      @(posedge clk); #1 ack_force = 1'b0;
      @(negedge clk);
      n_cmp++; if (grant !== 3'b000 || to_count !== '0) begin n_bad++; $display("FAIL rmid_state: grant %b cnt %0d want 000/0", grant, to_count); end
      drop(0);
      @(posedge clk); #1 rst = 1'b0;
      sl_wait = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++; if (grant !== 3'b000 || m_ack !== 3'b000 || m_err !== 3'b000)
            begin n_bad++; $display("FAIL rmid_after%0d: grant %b ack %b err %b want 0", i, grant, m_ack, m_err); end
      end
      settle(1);
      glob_last = N - 1;
   endtask

   task automatic test_random;
      logic [N-1:0] av, ev, pend, newm; logic [31:0] rd, as, ws; bit tmo, got;
      logic t_we [N]; logic [3:0] t_wd [N]; logic [31:0] t_dat [N]; logic [3:0] t_sel [N];
      int exp, beats;
      pend = '0;
      rst = 1'b1; settle(2); rst = 1'b0;
      glob_last = N - 1;
      for (int t = 0; t < 40; t++) begin
         newm = N'($urandom_range(0, 7)) & ~pend;
         if (pend == '0 && newm == '0) newm = N'(1) << $urandom_range(0, N - 1);
         for (int k = 0; k < N; k++) begin
            if (newm[k]) begin
               t_we[k] = 1'($urandom_range(0, 1)); t_wd[k] = 4'($urandom_range(0, 15));
               t_dat[k] = $urandom; t_sel[k] = t_we[k] ? 4'($urandom_range(1, 15)) : 4'hF;
               set_req(k, t_we[k], {26'b0, t_wd[k], 2'b0}, t_dat[k], t_sel[k]);
            end
         end
         pend = pend | newm;
         sl_wait = $urandom_range(0, 2);
         exp = rr_pick(glob_last, pend);
         got = 0;
         for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (grant !== '0) got = 1;
         end
         n_cmp++; if (!got || grant !== (N'(1) << exp)) begin n_bad++; $display("FAIL rnd%0d_grant: got %b want master %0d (req %b)", t, grant, exp, pend); end
         beats = $urandom_range(1, 3);
         for (int b = 0; b < beats; b++) begin
            if (b > 0) begin
               t_we[exp] = 1'($urandom_range(0, 1)); t_wd[exp] = 4'($urandom_range(0, 15));
               t_dat[exp] = $urandom; t_sel[exp] = t_we[exp] ? 4'($urandom_range(1, 15)) : 4'hF;
               set_req(exp, t_we[exp], {26'b0, t_wd[exp], 2'b0}, t_dat[exp], t_sel[exp]);
            end
            run_beat(exp, av, ev, rd, as, ws, tmo);
            n_cmp++; if (tmo || av !== (N'(1) << exp) || ev !== '0 || as !== {26'b0, t_wd[exp], 2'b0})
               begin n_bad++; $display("FAIL rnd%0d_beat%0d: ack %b err %b adr %h master %0d", t, b, av, ev, as, exp); end
            if (t_we[exp]) begin
               n_cmp++; if (ws !== t_dat[exp]) begin n_bad++; $display("FAIL rnd%0d_wdat%0d: got %h want %h", t, b, ws, t_dat[exp]); end
               for (int y = 0; y < 4; y++)
                  if (t_sel[exp][y]) ref_mem[t_wd[exp]][8*y +: 8] = t_dat[exp][8*y +: 8];
            end else begin
               n_cmp++; if (rd !== ref_mem[t_wd[exp]]) begin n_bad++; $display("FAIL rnd%0d_rdat%0d: got %h want %h", t, b, rd, ref_mem[t_wd[exp]]); end
            end
         end
         drop(exp);
         pend[exp] = 1'b0;
         glob_last = exp;
         settle(1);
      end
      for (int k = 0; k < N; k++) drop(k);
      settle(3);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_cmp = 0; n_bad = 0; glob_last = N - 1;
      m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
      sl_ack = 1'b0; sl_err = 1'b0; sl_cnt = 0; sl_wait = 0; sl_err_mode = 0;
      sl_rdat = '0; ack_force = 1'b0; rst = 1'b1;
      for (int i = 0; i < 16; i++) begin smem[i] = '0; ref_mem[i] = '0; end
      test_reset;
      test_contention;
      test_single_write;
      test_fairness;
      test_timeout;
      test_slave_err;
      test_reset_mid;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Round-robin Wishbone arbiter that lets C_NUM_MASTERS bus masters share one 32-bit Wishbone slave port. The slave port is typically a register-file peripheral such as the software register block. The arbiter locks the bus to one master for the whole of its cycle (cyc high) and routes ack/err/data back to that master only. A watchdog terminates stalled strobes with an error and counts these events for software diagnostics.

Parameters:
C_NUM_MASTERS, 2, number of requesting masters (2..8)
C_TIMEOUT, 1024, cycles a strobe may wait for ack/err before the arbiter errors it (>=2)
C_TO_CNT_WIDTH, 16, width of the saturating timeout event counter

Ports:
wb_clk_i  in  1  single system clock, all logic on rising edge
wb_rst_i  in  1  synchronous, active-high reset
m_cyc_i  in  N  per-master cycle
m_stb_i  in  N  per-master strobe
m_we_i  in  N  per-master write enable
m_sel_i  in  4N  per-master byte selects, master k at [4k+3:4k]
m_adr_i  in  32N  per-master address, master k at [32k+31:32k]
m_dat_i  in  32N  per-master write data, same packing
m_dat_o  out  32  read data, broadcast to all masters (= s_dat_i)
m_ack_o  out  N  per-master ack
m_err_o  out  N  per-master error
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_we_o  out  1  slave write enable
s_sel_o  out  4  slave byte selects
s_adr_o  out  32  slave address
s_dat_o  out  32  slave write data
s_dat_i  in  32  slave read data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave error
grant_o  out  N  one-hot current owner; 0 when idle
to_count_o  out  C_TO_CNT_WIDTH  saturating count of watchdog timeouts

Behaviour:
- Reset values:
  - state IDLE, grant_o=0, last_owner=N-1 (so master 0 has first priority), timer=0, to_count_o=0.
  - While wb_rst_i is high, s_cyc_o, s_stb_o, m_ack_o and m_err_o are forced to 0 combinationally.
- Request: master k requests when m_cyc_i[k] && m_stb_i[k].
- IDLE:
  - If any request exists, pick the first requester searching last_owner+1, +2, ... with modulo-N wrap.
  - Register owner, go to BUSY. Grant takes effect the next cycle; there is no combinational grant.
  - Simultaneous requests resolve by this search order.
- BUSY:
  - s_cyc_o=m_cyc_i[owner]; s_stb_o=m_stb_i[owner] (except the timeout cycle).
  - s_we/sel/adr/dat_o are a mux of the owner's inputs.
  - m_ack_o[owner]=s_ack_i and m_err_o[owner]=s_err_i, combinational pass-through. Non-owners see ack/err = 0.
  - When m_cyc_i[owner] is low at a clock edge: last_owner<=owner, go to IDLE. This gives exactly one idle cycle between owners.
- Non-owners stall with no response; their requests are not lost and stay pending.
- Latency: request at edge t. s_stb_o is high during cycle t+1. With a 1-cycle-ack slave, m_ack_o is seen during cycle t+2.
- Watchdog:
  - Timer increments each BUSY cycle with s_stb_o && !s_ack_i && !s_err_i. It clears on ack, err, stb low or leaving BUSY.
  - When timer == C_TIMEOUT-1, that cycle: s_stb_o forced 0, m_err_o[owner]=1 for exactly one cycle. Next edge: timer<=0, to_count_o increments, saturating at all-ones. Owner keeps the bus until it drops cyc.
  - s_ack_i in the same cycle as the timeout wins: normal ack, no err, no count.
- Multi-beat: the owner may issue back-to-back strobes within one cyc. Each beat is handled independently; the timer restarts per beat.
- Reset mid-transaction: outputs gate low immediately; state returns to IDLE at the edge; the in-flight transfer is discarded with no ack/err.
- Invalid owner encodings are unreachable; a default branch returns to IDLE.

Test Plan:
- Reset: assert wb_rst_i 3 cycles with m_cyc/stb=2'b11 -> s_cyc_o=0, grant_o=0, to_count_o=0 throughout. After release, grant_o=2'b01 on the second edge.
- Single write: master 1 writes 0xDEADBEEF to 0x0, sel=4'hF, into a 1-cycle-ack register slave. Required: grant_o=2'b10, s_adr_o=0, s_dat_o=0xDEADBEEF, m_ack_o=2'b10 two cycles after the request. A readback by master 1 then returns 0xDEADBEEF on m_dat_o.
- Contention: both masters request at the same edge after reset. Master 0 is served first. After it drops cyc there is one idle cycle, then grant_o=2'b10. Repeat with both requesting -> master 0 again (alternation).
- Fairness: master 0 re-requests immediately after every cycle while master 1 holds its request continuously. Required: grants alternate 01,10,01,10 over 4 transactions.
- Timeout: C_TIMEOUT=8, slave never acks, master 0 strobes. Required: m_err_o[0]=1 in the 8th strobe cycle only, s_stb_o=0 that cycle, to_count_o=1. A second stall gives to_count_o=2. Ack arriving in cycle 8 -> ack, no err, count unchanged.
- Reset mid-transfer: assert wb_rst_i while s_stb_o=1 with the slave stalled. Required: s_stb_o=0 the same cycle, no m_ack/m_err, state IDLE afterwards, to_count_o=0.
